iob_plic_claim_arbiter: RTL and testbench
=========================================

// Module: iob_plic_claim_arbiter
// PURPOSE
//  Per-target scheduler for the IOb PLIC: scans all interrupt sources, selects the highest-priority
//  eligible pending source and drives that target's meip line. It also runs the claim/complete
//  handshake: a claim returns the winning ID, pulses that source's gateway clear and marks the
//  source in-service until completed. One instance per target, between the gateways and register file.
// PARAMETERS
//  SOURCES    8                    number of interrupt sources; IDs 1..SOURCES, ID 0 = none
//  PRIORITIES 8                    number of priority levels; level 0 = never interrupts
//  PRIO_W     $clog2(PRIORITIES)   width of one priority field
//  ID_W       $clog2(SOURCES+1)    width of a source ID
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous active-high reset
//  pending      in   SOURCES         gateway pending bits; bit i-1 = source ID i
//  enable       in   SOURCES         per-target enable bits for this target
//  priority     in   SOURCES*PRIO_W  flat priorities; field i-1 = source ID i
//  threshold    in   PRIO_W          target threshold (used only with PLIC_THRESHOLD_EN)
//  claim_valid  in   1               claim request (one-cycle pulse from register read)
//  claim_ready  out  1               claim response strobe
//  claim_id     out  ID_W            claimed ID, valid while claim_ready=1
//  complete_valid in 1               complete request
//  complete_id  in   ID_W            ID being completed
//  clear        out  SOURCES         one-cycle one-hot pulse clearing the gateway of the claimed source
//  irq          out  1               meip for this target
//  best_id      out  ID_W            last published winner (debug/readback)
// BEHAVIOUR
//  - Reset: irq=0, claim_ready=0, claim_id=0, clear=0, best_id=0, in_service=0, FSM=SCAN, index=1.
//  - Eligible(i) = pending[i-1] & enable[i-1] & ~in_service[i-1] & (prio(i)!=0).
//  - FSM SCAN: one source per cycle, index 1..SOURCES; candidate replaced only if prio strictly greater
//    -> ties go to lowest ID. Candidate starts each scan as (id 0, prio 0).
//  - FSM PUBLISH (1 cycle, after index=SOURCES): best_id<=candidate id, irq<=(candidate id!=0);
//    index<=1, back to SCAN. Scan period SOURCES+1 cycles; worst-case pending->irq latency
//    2*(SOURCES+1) cycles.
//  - Claim: claim_valid sampled at edge N -> at edge N+1 claim_ready=1 for exactly one cycle,
//    claim_id=best_id as seen at edge N. If that ID!=0: clear[ID-1]=1 same cycle, in_service[ID-1]<=1,
//    best_id<=0, irq<=0, scan aborted and restarted at index 1. If 0: no clear, no state change.
//  - claim_valid while claim_ready=1 is accepted normally (back-to-back claims allowed, each returns
//    the then-current best_id; second returns 0 until the restarted scan publishes).
//  - Complete: complete_valid with 1<=complete_id<=SOURCES clears in_service[id-1] next edge.
//    ID 0, ID>SOURCES, or ID not in-service: ignored, no error.
//  - Claim and complete same cycle: both apply; if same ID, the claim's set of in_service wins.
//  - Inputs pending/enable/priority may change mid-scan; already-visited sources use sampled values,
//    the change is seen next scan. Deasserted winner drops at next PUBLISH.
//  - Reset mid-scan or mid-claim: all state returns to reset values on the next edge; no clear pulse.
//  - Arithmetic: priority compare unsigned PRIO_W bits; index counter ID_W bits, never wraps past SOURCES.
// CONFIGURATION
//  - PLIC_THRESHOLD_EN defined: Eligible(i) additionally requires prio(i) > threshold (strict);
//    threshold=PRIORITIES-1 masks every source.
//  - Not defined: threshold port present but ignored; only the prio!=0 rule applies.
// TESTING (SOURCES=8, PRIORITIES=8)
//  - Reset held 3 cycles with pending=8'hFF enabled -> irq, claim_ready, claim_id, clear, best_id all 0.
//  - ID3 prio5, ID6 prio7, both enabled/pending -> irq=1 within 18 cycles; claim -> next cycle
//    claim_ready=1, claim_id=6, clear=8'b0010_0000; irq=0 until next PUBLISH then irq=1, best_id=3.
//  - ID2 and ID4 both prio4 -> best_id=2; enable[1]=0 -> best_id=4 after next PUBLISH.
//  - No eligible source, claim -> claim_ready=1, claim_id=0, clear=0, in_service unchanged.
//  - Claim ID6, keep pending[5]=1 -> ID6 never wins; complete_id=6 -> best_id=6 within 18 cycles;
//    complete_id=0 or 9 -> no effect.
//  - PLIC_THRESHOLD_EN, threshold=5: ID1 prio5 -> irq stays 0 for 40 cycles; prio6 -> irq=1, best_id=1.

Source files
------------

// File: rtl/iob_plic_claim_arbiter.sv
// iob_plic_claim_arbiter: per-target PLIC scheduler with a claim/complete handshake.
// It scans the interrupt sources one per cycle and keeps the highest-priority eligible
// source as the candidate. Ties go to the lowest ID. After the last source, it publishes
// the candidate as best_id and drives irq.
// A claim returns best_id, pulses that source's gateway clear and marks the source
// in-service until a complete arrives.
// The per-source priorities arrive on priority_flat. The plain name is a reserved word.
// Optional feature: define PLIC_THRESHOLD_EN to require prio > threshold for eligibility.
module iob_plic_claim_arbiter #(
  parameter int unsigned SOURCES    = 8,
  parameter int unsigned PRIORITIES = 8,
  parameter int unsigned PRIO_W     = $clog2(PRIORITIES),
  parameter int unsigned ID_W       = $clog2(SOURCES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SOURCES-1:0]          pending,
  input  logic [SOURCES-1:0]          enable,
  input  logic [SOURCES*PRIO_W-1:0]   priority_flat,
  input  logic [PRIO_W-1:0]           threshold,
  input  logic                        claim_valid,
  output logic                        claim_ready,
  output logic [ID_W-1:0]             claim_id,
  input  logic                        complete_valid,
  input  logic [ID_W-1:0]             complete_id,
  output logic [SOURCES-1:0]          clear,
  output logic                        irq,
  output logic [ID_W-1:0]             best_id
);

  typedef enum logic {
    ST_SCAN    = 1'b0,
    ST_PUBLISH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     index_q, index_d;
  logic [ID_W-1:0]     cand_id_q, cand_id_d;
  logic [PRIO_W-1:0]   cand_prio_q, cand_prio_d;
  logic [ID_W-1:0]     best_id_q, best_id_d;
  logic                irq_q, irq_d;
  logic                claim_ready_q, claim_ready_d;
  logic [ID_W-1:0]     claim_id_q, claim_id_d;
  logic [SOURCES-1:0]  clear_q, clear_d;
  logic [SOURCES-1:0]  in_service_q, in_service_d;

  logic                sel_pend_c;
  logic                sel_en_c;
  logic                sel_ins_c;
  logic [PRIO_W-1:0]   sel_prio_c;
  logic                sel_elig_c;
  logic                claim_win_c;
  logic                complete_hit_c;

  // Pick out the inputs of the source that the scan index points at
  always_comb begin
    sel_pend_c = 1'b0;
    sel_en_c   = 1'b0;
    sel_ins_c  = 1'b0;
    sel_prio_c = '0;
    for (int unsigned s = 0; s < SOURCES; s++) begin
      if (index_q == ID_W'(s + 1)) begin
        sel_pend_c = pending[s];
        sel_en_c   = enable[s];
        sel_ins_c  = in_service_q[s];
        sel_prio_c = priority_flat[s*PRIO_W +: PRIO_W];
      end
    end
  end

  // Eligibility of the currently scanned source
  always_comb begin
    sel_elig_c = sel_pend_c & sel_en_c & ~sel_ins_c & (sel_prio_c != '0);
`ifdef PLIC_THRESHOLD_EN
    sel_elig_c = sel_elig_c & (sel_prio_c > threshold);
`endif
  end

`ifndef PLIC_THRESHOLD_EN
  // threshold only matters when the threshold feature is built in
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  // A claim takes effect only when a winner is published
  assign claim_win_c    = claim_valid & (best_id_q != '0);
  assign complete_hit_c = complete_valid & (complete_id != '0) &
                          (complete_id <= ID_W'(SOURCES));

  // Claim response, gateway clear pulse and in-service tracking
  always_comb begin
    claim_ready_d = claim_valid;
    claim_id_d    = claim_valid ? best_id_q : '0;
    clear_d       = '0;
    in_service_d  = in_service_q;
    for (int unsigned s = 0; s < SOURCES; s++) begin
      if (complete_hit_c && (complete_id == ID_W'(s + 1))) begin
        in_service_d[s] = 1'b0;
      end
      // A claim applied after the complete wins when both target one ID
      if (claim_win_c && (best_id_q == ID_W'(s + 1))) begin
        in_service_d[s] = 1'b1;
        clear_d[s]      = 1'b1;
      end
    end
  end

  // Scan / publish FSM next state; a successful claim aborts and restarts the scan
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cand_id_d   = cand_id_q;
    cand_prio_d = cand_prio_q;
    best_id_d   = best_id_q;
    irq_d       = irq_q;
    case (state_q)
      ST_SCAN: begin
        // Strictly-greater replacement keeps the lowest ID on ties
        if (sel_elig_c && (sel_prio_c > cand_prio_q)) begin
          cand_id_d   = index_q;
          cand_prio_d = sel_prio_c;
        end
        if (index_q == ID_W'(SOURCES)) begin
          state_d = ST_PUBLISH;
        end else begin
          index_d = index_q + ID_W'(1);
        end
      end
      ST_PUBLISH: begin
        best_id_d   = cand_id_q;
        irq_d       = (cand_id_q != '0);
        index_d     = ID_W'(1);
        cand_id_d   = '0;
        cand_prio_d = '0;
        state_d     = ST_SCAN;
      end
      default: begin
        state_d     = ST_SCAN;
        index_d     = ID_W'(1);
        cand_id_d   = '0;
        cand_prio_d = '0;
      end
    endcase
    if (claim_win_c) begin
      best_id_d   = '0;
      irq_d       = 1'b0;
      state_d     = ST_SCAN;
      index_d     = ID_W'(1);
      cand_id_d   = '0;
      cand_prio_d = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SCAN;
      index_q       <= ID_W'(1);
      cand_id_q     <= '0;
      cand_prio_q   <= '0;
      best_id_q     <= '0;
      irq_q         <= 1'b0;
      claim_ready_q <= 1'b0;
      claim_id_q    <= '0;
      clear_q       <= '0;
      in_service_q  <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      cand_id_q     <= cand_id_d;
      cand_prio_q   <= cand_prio_d;
      best_id_q     <= best_id_d;
      irq_q         <= irq_d;
      claim_ready_q <= claim_ready_d;
      claim_id_q    <= claim_id_d;
      clear_q       <= clear_d;
      in_service_q  <= in_service_d;
    end
  end

  assign claim_ready = claim_ready_q;
  assign claim_id    = claim_id_q;
  assign clear       = clear_q;
  assign irq         = irq_q;
  assign best_id     = best_id_q;

endmodule

// File: tb/tb_iob_plic_claim_arbiter.sv
// Testbench for iob_plic_claim_arbiter (SOURCES=8, PRIORITIES=8).
// Directed scenarios plus randomized traffic are checked against an argmax reference model.
// The threshold scenario follows PLIC_THRESHOLD_EN.
module tb_iob_plic_claim_arbiter;

  localparam int unsigned S  = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  pending;
  logic [S-1:0]  enable;
  logic [S*PW-1:0] priority_flat;
  logic [PW-1:0] threshold;
  logic          claim_valid;
  logic          claim_ready;
  logic [IW-1:0] claim_id;
  logic          complete_valid;
  logic [IW-1:0] complete_id;
  logic [S-1:0]  clear;
  logic          irq;
  logic [IW-1:0] best_id;

  logic [PW-1:0] prio_a [S];
  logic [S-1:0]  m_ins;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < S; s++) priority_flat[s*PW +: PW] = prio_a[s];
  end

  iob_plic_claim_arbiter #(.SOURCES(8), .PRIORITIES(8)) dut (
    .clk(clk), .rst(rst), .pending(pending), .enable(enable),
    .priority_flat(priority_flat), .threshold(threshold),
    .claim_valid(claim_valid), .claim_ready(claim_ready), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .clear(clear), .irq(irq), .best_id(best_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Highest priority eligible source, lowest ID on ties; 0 when none
  function automatic int model_best();
    int best = 0;
    int bp = 0;
    for (int i = 1; i <= S; i++) begin
      int p = int'(prio_a[i-1]);
      bit el = pending[i-1] && enable[i-1] && !m_ins[i-1] && (p != 0);
`ifdef PLIC_THRESHOLD_EN
      el = el && (p > int'(threshold));
`endif
      if (el && p > bp) begin
        best = i;
        bp = p;
      end
    end
    return best;
  endfunction

  function automatic logic [S-1:0] onehot(int id);
    logic [S-1:0] v = '0;
    if (id >= 1 && id <= S) v[id-1] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pending = '0;
    enable = '0;
    threshold = '0;
    claim_valid = 1'b0;
    complete_valid = 1'b0;
    complete_id = '0;
    for (int s = 0; s < S; s++) prio_a[s] = '0;
    m_ins = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pending = 8'hFF;
    enable = 8'hFF;
    for (int s = 0; s < S; s++) prio_a[s] = 3'd7;
    repeat (20) tick();
    // Reset arrives together with a claim; no clear pulse may follow
    rst = 1'b1;
    claim_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      claim_valid = 1'b0;
      n_cmp++;
      if ({irq, claim_ready, claim_id, clear, best_id} !== '0) begin
        n_fail++;
        $display("FAIL reset_c%0d: irq=%b rdy=%b cid=%0d clr=%b best=%0d required all 0",
                 c, irq, claim_ready, claim_id, clear, best_id);
      end
    end
    rst = 1'b0;
    m_ins = '0;
  endtask

  task automatic test_basic_claim();
    int c;
    do_reset();
    prio_a[2] = 3'd5;
    prio_a[5] = 3'd7;
    pending = 8'b0010_0100;
    enable = 8'b0010_0100;
    for (c = 0; c < 18 && irq !== 1'b1; c++) tick();
    n_cmp++;
    if (irq !== 1'b1 || best_id !== 4'd6) begin
      n_fail++;
      $display("FAIL basic_irq: irq=%b best=%0d required 1/6", irq, best_id);
    end
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_cmp++;
    if (claim_ready !== 1'b1 || claim_id !== 4'd6 || clear !== 8'b0010_0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_claim: rdy=%b cid=%0d clr=%b irq=%b required 1/6/00100000/0",
               claim_ready, claim_id, clear, irq);
    end
    tick();
    n_cmp++;
    if (claim_ready !== 1'b0 || clear !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse: rdy=%b clr=%b irq=%b required 0/0/0", claim_ready, clear, irq);
    end
    for (c = 0; c < 18 && irq !== 1'b1; c++) tick();
    n_cmp++;
    if (irq !== 1'b1 || best_id !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_next: irq=%b best=%0d required 1/3", irq, best_id);
    end
  endtask

  task automatic test_tie();
    do_reset();
    prio_a[1] = 3'd4;
    prio_a[3] = 3'd4;
    pending = 8'b0000_1010;
    enable = 8'b0000_1010;
    repeat (20) tick();
    n_cmp++;
    if (best_id !== 4'd2) begin
      n_fail++;
      $display("FAIL tie_low_id: best=%0d required 2", best_id);
    end
    enable[1] = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (best_id !== 4'd4) begin
      n_fail++;
      $display("FAIL tie_disable: best=%0d required 4", best_id);
    end
  endtask

  task automatic test_no_eligible();
    do_reset();
    prio_a[4] = 3'd3;
    enable = 8'hFF;
    repeat (20) tick();
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_cmp++;
    if (claim_ready !== 1'b1 || claim_id !== 4'd0 || clear !== 8'h00) begin
      n_fail++;
      $display("FAIL empty_claim: rdy=%b cid=%0d clr=%b required 1/0/0", claim_ready, claim_id, clear);
    end
    // A claim that returned 0 must not have put any source in service
    pending = 8'b0001_0000;
    repeat (20) tick();
    n_cmp++;
    if (best_id !== 4'd5 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_no_ins: best=%0d irq=%b required 5/1", best_id, irq);
    end
  endtask

  task automatic test_complete();
    bit seen6 = 1'b0;
    int c;
    do_reset();
    prio_a[5] = 3'd7;
    pending = 8'b0010_0000;
    enable = 8'b0010_0000;
    repeat (20) tick();
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_cmp++;
    if (claim_id !== 4'd6) begin
      n_fail++;
      $display("FAIL cmp_claim: cid=%0d required 6", claim_id);
    end
    for (c = 0; c < 40; c++) begin
      tick();
      if (best_id === 4'd6 || irq === 1'b1) seen6 = 1'b1;
    end
    n_cmp++;
    if (seen6) begin
      n_fail++;
      $display("FAIL cmp_in_service: in-service ID6 won again, required never");
    end
    for (int k = 0; k < 2; k++) begin
      complete_valid = 1'b1;
      complete_id = (k == 0) ? 4'd0 : 4'd9;
      tick();
      complete_valid = 1'b0;
      repeat (20) tick();
      n_cmp++;
      if (best_id !== 4'd0) begin
        n_fail++;
        $display("FAIL cmp_ignored_%0d: best=%0d required 0", k, best_id);
      end
    end
    complete_valid = 1'b1;
    complete_id = 4'd6;
    tick();
    complete_valid = 1'b0;
    for (c = 0; c < 18 && best_id !== 4'd6; c++) tick();
    n_cmp++;
    if (best_id !== 4'd6 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_release: best=%0d irq=%b required 6/1", best_id, irq);
    end
  endtask

  task automatic test_threshold();
    int c;
    bit rose = 1'b0;
    do_reset();
    pending = 8'h01;
    enable = 8'h01;
`ifdef PLIC_THRESHOLD_EN
    threshold = 3'd5;
    prio_a[0] = 3'd5;
    for (c = 0; c < 40; c++) begin
      tick();
      if (irq !== 1'b0) rose = 1'b1;
    end
    n_cmp++;
    if (rose) begin
      n_fail++;
      $display("FAIL thr_equal: irq rose with prio==threshold, required 0");
    end
    prio_a[0] = 3'd6;
    for (c = 0; c < 18 && irq !== 1'b1; c++) tick();
    n_cmp++;
    if (irq !== 1'b1 || best_id !== 4'd1) begin
      n_fail++;
      $display("FAIL thr_above: irq=%b best=%0d required 1/1", irq, best_id);
    end
`else
    threshold = 3'd7;
    prio_a[0] = 3'd1;
    for (c = 0; c < 18 && irq !== 1'b1; c++) tick();
    n_cmp++;
    if (irq !== 1'b1 || best_id !== 4'd1) begin
      n_fail++;
      $display("FAIL thr_ignored: irq=%b best=%0d required 1/1", irq, best_id);
    end
    for (c = 0; c < 20; c++) begin
      tick();
      if (irq !== 1'b1) rose = 1'b1;
    end
    n_cmp++;
    if (rose) begin
      n_fail++;
      $display("FAIL thr_ignored_hold: irq dropped, required steady 1");
    end
`endif
  endtask

  task automatic test_random();
    int exp, nclaims, cid;
    bit do_comp;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      pending = 8'($urandom);
      enable = 8'($urandom);
      for (int s = 0; s < S; s++) prio_a[s] = 3'($urandom_range(0, 7));
`ifdef PLIC_THRESHOLD_EN
      threshold = 3'($urandom_range(0, 4));
`else
      threshold = 3'($urandom);
`endif
      repeat (20) tick();
      exp = model_best();
      n_cmp++;
      if (best_id !== 4'(exp) || irq !== (exp != 0)) begin
        n_fail++;
        $display("FAIL rnd_best_%0d: best=%0d irq=%b required %0d/%b", it, best_id, irq, exp, exp != 0);
      end
      nclaims = $urandom_range(0, 2);
      do_comp = 1'($urandom_range(0, 1));
      cid = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 8) : $urandom_range(0, 15);
      if (nclaims == 0 && !do_comp) continue;
      claim_valid = (nclaims >= 1);
      complete_valid = do_comp;
      complete_id = 4'(cid);
      tick();
      claim_valid = (nclaims == 2);
      complete_valid = 1'b0;
      if (do_comp && cid >= 1 && cid <= S) m_ins[cid-1] = 1'b0;
      if (nclaims >= 1) begin
        m_ins = m_ins | onehot(exp);
        n_cmp++;
        if (claim_ready !== 1'b1 || claim_id !== 4'(exp) || clear !== onehot(exp) ||
            (exp != 0 && irq !== 1'b0)) begin
          n_fail++;
          $display("FAIL rnd_claim_%0d: rdy=%b cid=%0d clr=%b irq=%b required 1/%0d/%b",
                   it, claim_ready, claim_id, clear, irq, exp, onehot(exp));
        end
      end else begin
        n_cmp++;
        if (claim_ready !== 1'b0 || clear !== 8'h00) begin
          n_fail++;
          $display("FAIL rnd_idle_%0d: rdy=%b clr=%b required 0/0", it, claim_ready, clear);
        end
      end
      tick();
      claim_valid = 1'b0;
      if (nclaims == 2) begin
        // Second claim sees best_id already cleared (or still 0)
        n_cmp++;
        if (claim_ready !== 1'b1 || claim_id !== 4'd0 || clear !== 8'h00) begin
          n_fail++;
          $display("FAIL rnd_b2b_%0d: rdy=%b cid=%0d clr=%b required 1/0/0",
                   it, claim_ready, claim_id, clear);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_claim();
    test_tie();
    test_no_eligible();
    test_complete();
    test_threshold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
